bf16_unpack: RTL and testbench

BF16_UNPACK -- requirements
Module: bf16_unpack

---
 rtl/bf16_pkg.sv | 28 ++
 rtl/bf16_field_decode.sv | 31 +++
 rtl/bf16_unpack.sv | 113 +++++++++++
 tb/tb_bf16_unpack.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// bfloat16 unpack shared types and constants.
// Subnormal handling in bf16_field_decode is selected by the BF16_DENORM_EN macro.
package bf16_pkg;
  localparam int         BIAS    = 127;
  localparam logic [7:0] EXP_MAX = 8'd255;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  // one decoded operand
  typedef struct packed {
    logic       hidden;
    logic       is_zero;
    logic       is_inf;
    logic       is_nan;
    logic [7:0] eff_exp;
  } dec_t;

  // S1 register contents: per-operand decode plus raw fractions
  typedef struct packed {
    logic                sign;
    dec_t [1:0]          dec;
    logic [1:0][6:0]     frac;
  } s1_t;
endpackage

// File: rtl/bf16_field_decode.sv
// Classify one bfloat16 operand and produce its hidden bit and effective exponent.
// BF16_DENORM_EN: subnormals keep hidden=0 with exponent 1; otherwise flushed to zero.
module bf16_field_decode
  import bf16_pkg::*;
(
  input  logic [7:0] exp_i,
  input  logic [6:0] frac_i,
  output dec_t       dec_o
);
  // classification; everything else (incl. flushed subnormals) leaves eff_exp 0
  always_comb begin
    dec_o = '0;
    if (exp_i == EXP_MAX) begin
      dec_o.is_nan = |frac_i;
      dec_o.is_inf = ~|frac_i;
    end else if (exp_i == 8'd0) begin
      if (frac_i == 7'd0) begin
        dec_o.is_zero = 1'b1;
      end else begin
`ifdef BF16_DENORM_EN
        dec_o.eff_exp = 8'd1;
`else
        dec_o.is_zero = 1'b1;
`endif
      end
    end else begin
      dec_o.hidden  = 1'b1;
      dec_o.eff_exp = exp_i;
    end
  end
endmodule

// File: rtl/bf16_unpack.sv
// 2-stage valid/ready unpack of a bfloat16 operand pair for a multiplier.
// S1 holds decoded fields, S2 holds exponent sum, masked mantissas and flags.
// BF16_DENORM_EN (in bf16_field_decode) selects subnormal support.
module bf16_unpack
  import bf16_pkg::*;
#(
  parameter int BIAS  = bf16_pkg::BIAS,
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      op_a_i,
  input  logic [15:0]      op_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             sign_o,
  output logic [EXP_W-1:0] exponent_o,
  output logic [7:0]       mant_a_o,
  output logic [7:0]       mant_b_o,
  output logic             zero_o,
  output logic             inf_o,
  output logic             nan_o
);
  bf16_t [1:0] ops;
  dec_t  [1:0] dec;
  s1_t         s1_d, s1_q;
  logic        v1_q, v2_q, en1, en2;

  assign ops[0] = bf16_t'(op_a_i);
  assign ops[1] = bf16_t'(op_b_i);

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dec
      bf16_field_decode u_dec (
        .exp_i  (ops[g].exp),
        .frac_i (ops[g].frac),
        .dec_o  (dec[g])
      );
    end
  endgenerate

  assign en2        = !v2_q | out_ready_i;
  assign en1        = !v1_q | en2;
  assign in_ready_o = en1;

  // S1 next state
  always_comb begin
    s1_d         = '0;
    s1_d.sign    = ops[0].sign ^ ops[1].sign;
    s1_d.dec     = dec;
    s1_d.frac[0] = ops[0].frac;
    s1_d.frac[1] = ops[1].frac;
  end

  // S2 next state: special-case priority nan > inf > zero, data masked when flagged
  logic             nan_d, inf_d, zero_d, any_sp;
  logic [EXP_W-1:0] exp_d;
  logic [7:0]       ma_d, mb_d;
  always_comb begin
    nan_d  = s1_q.dec[0].is_nan | s1_q.dec[1].is_nan
           | (s1_q.dec[0].is_inf & s1_q.dec[1].is_zero)
           | (s1_q.dec[0].is_zero & s1_q.dec[1].is_inf);
    inf_d  = !nan_d & (s1_q.dec[0].is_inf | s1_q.dec[1].is_inf);
    zero_d = !nan_d & !inf_d & (s1_q.dec[0].is_zero | s1_q.dec[1].is_zero);
    any_sp = nan_d | inf_d | zero_d;
    exp_d  = EXP_W'(s1_q.dec[0].eff_exp) + EXP_W'(s1_q.dec[1].eff_exp) - EXP_W'(BIAS);
    ma_d   = {s1_q.dec[0].hidden, s1_q.frac[0]};
    mb_d   = {s1_q.dec[1].hidden, s1_q.frac[1]};
    if (any_sp) begin
      exp_d = '0;
      ma_d  = '0;
      mb_d  = '0;
    end
  end

  // pipeline registers; each stage holds while its downstream is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      s1_q        <= '0;
      sign_o      <= 1'b0;
      exponent_o  <= '0;
      mant_a_o    <= '0;
      mant_b_o    <= '0;
      zero_o      <= 1'b0;
      inf_o       <= 1'b0;
      nan_o       <= 1'b0;
    end else begin
      if (en1) begin
        v1_q <= in_valid_i;
        if (in_valid_i) s1_q <= s1_d;
      end
      if (en2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sign_o     <= s1_q.sign;
          exponent_o <= exp_d;
          mant_a_o   <= ma_d;
          mant_b_o   <= mb_d;
          zero_o     <= zero_d;
          inf_o      <= inf_d;
          nan_o      <= nan_d;
        end
      end
    end
  end

  assign out_valid_o = v2_q;
endmodule

// File: tb/tb_bf16_unpack.sv
// Scoreboard bench for bf16_unpack: expectations queued at acceptance, checked at emission.
module tb_bf16_unpack;
  localparam int EXP_W = 10;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic             in_ready_o, out_valid_o;
  logic [15:0]      op_a_i = '0, op_b_i = '0;
  logic             sign_o, zero_o, inf_o, nan_o;
  logic [EXP_W-1:0] exponent_o;
  logic [7:0]       mant_a_o, mant_b_o;

  bf16_unpack #(.BIAS(127), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .sign_o(sign_o), .exponent_o(exponent_o),
    .mant_a_o(mant_a_o), .mant_b_o(mant_b_o),
    .zero_o(zero_o), .inf_o(inf_o), .nan_o(nan_o)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [29:0] sb[$];
  logic        stall_prev = 1'b0;
  logic [29:0] prev_v = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] pk(logic s, logic [9:0] e, logic [7:0] ma, logic [7:0] mb,
                                     logic z, logic i, logic n);
    return {s, e, ma, mb, z, i, n};
  endfunction

  function automatic logic [29:0] outvec();
    return pk(sign_o, exponent_o, mant_a_o, mant_b_o, zero_o, inf_o, nan_o);
  endfunction

  // reference: classify each operand, then apply nan > inf > zero
  function automatic logic [29:0] model(logic [15:0] a, logic [15:0] b);
    logic [15:0] op[2];
    logic        z[2], inf[2], nan[2];
    logic [7:0]  m[2];
    int          eff[2], e;
    logic        n, i, zz, den;
`ifdef BF16_DENORM_EN
    den = 1'b1;
`else
    den = 1'b0;
`endif
    op[0] = a; op[1] = b;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] ex; logic [6:0] fr; logic sub;
      ex = op[k][14:7]; fr = op[k][6:0];
      sub    = (ex == 0) && (fr != 0);
      nan[k] = (ex == 255) && (fr != 0);
      inf[k] = (ex == 255) && (fr == 0);
      z[k]   = ((ex == 0) && (fr == 0)) || (sub && !den);
      m[k]   = (ex != 0 && ex != 255) ? {1'b1, fr} : ((sub && den) ? {1'b0, fr} : 8'h00);
      eff[k] = (sub && den) ? 1 : int'(ex);
    end
    n  = nan[0] | nan[1] | (inf[0] & z[1]) | (z[0] & inf[1]);
    i  = !n && (inf[0] | inf[1]);
    zz = !n && !i && (z[0] | z[1]);
    e  = eff[0] + eff[1] - 127;
    if (n || i || zz) return pk(a[15] ^ b[15], 10'h0, 8'h0, 8'h0, zz, i, n);
    return pk(a[15] ^ b[15], e[9:0], m[0], m[1], 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic cmp_res(input logic [29:0] g, input logic [29:0] e);
    chk("sign",  {31'b0, g[29]},    {31'b0, e[29]});
    chk("exp",   {22'b0, g[28:19]}, {22'b0, e[28:19]});
    chk("mant_a",{24'b0, g[18:11]}, {24'b0, e[18:11]});
    chk("mant_b",{24'b0, g[10:3]},  {24'b0, e[10:3]});
    chk("flags", {29'b0, g[2:0]},   {29'b0, e[2:0]});
  endtask

  // one cycle: drive at negedge, evaluate handshakes mid-cycle, advance
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic rdy, input logic use_e, input logic [29:0] ev,
                      output logic acc);
    logic [29:0] cur, e;
    in_valid_i = v; op_a_i = a; op_b_i = b; out_ready_i = rdy;
    #1;
    cur = outvec();
    if (stall_prev) begin
      chk("hold_vld", {31'b0, out_valid_o}, 32'd1);
      chk("hold_data", {2'b0, cur}, {2'b0, prev_v});
    end
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) chk("unexpected_out", {31'b0, out_valid_o}, 32'd0);
      else begin
        e = sb.pop_front();
        cmp_res(cur, e);
      end
    end
    acc = v && in_ready_o;
    if (acc) sb.push_back(use_e ? ev : model(a, b));
    stall_prev = out_valid_o && !out_ready_i;
    prev_v     = cur;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 50 && sb.size() != 0; c++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, '0, acc);
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: r = {r[15], 15'h0};
      1: r = {r[15], 8'hFF, 7'h0};
      2: r = {r[15], 8'hFF, (r[6:0] == 0) ? 7'h1 : r[6:0]};
      3: r = {r[15], 8'h00, (r[6:0] == 0) ? 7'h5 : r[6:0]};
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic acc;
    int   na;
    logic [29:0] e37;
    // reset state
    #3;
    chk("rst_vld",   {31'b0, out_valid_o}, 32'd0);
    chk("rst_rdy",   {31'b0, in_ready_o},  32'd1);
    chk("rst_data",  {2'b0, outvec()},     32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // first-transaction latency
    step(1'b1, 16'h3F80, 16'h3F80, 1'b1, 1'b1, pk(0, 10'h07F, 8'h80, 8'h80, 0, 0, 0), acc);
    chk("acc_first", {31'b0, acc}, 32'd1);
    chk("lat1", {31'b0, out_valid_o}, 32'd0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, '0, acc);
    chk("lat2", {31'b0, out_valid_o}, 32'd1);
    drain();

    // directed values, back-to-back
`ifdef BF16_DENORM_EN
    e37 = pk(0, 10'd1, 8'h01, 8'h80, 0, 0, 0);
`else
    e37 = pk(0, 10'd0, 8'h00, 8'h00, 1, 0, 0);
`endif
    step(1'b1, 16'hC000, 16'h4040, 1'b1, 1'b1, pk(1, 10'd129, 8'h80, 8'hC0, 0, 0, 0), acc);
    step(1'b1, 16'h7F80, 16'h0000, 1'b1, 1'b1, pk(0, 10'd0, 8'h00, 8'h00, 0, 0, 1), acc);
    step(1'b1, 16'h7F80, 16'h3F80, 1'b1, 1'b1, pk(0, 10'd0, 8'h00, 8'h00, 0, 1, 0), acc);
    step(1'b1, 16'h7FC1, 16'h3F80, 1'b1, 1'b1, pk(0, 10'd0, 8'h00, 8'h00, 0, 0, 1), acc);
    step(1'b1, 16'h0001, 16'h3F80, 1'b1, 1'b1, e37, acc);
    step(1'b1, 16'h8000, 16'h3F80, 1'b1, 1'b1, pk(1, 10'd0, 8'h00, 8'h00, 1, 0, 0), acc);
    step(1'b1, 16'h7F7F, 16'h7F7F, 1'b1, 1'b1, pk(0, 10'd381, 8'hFF, 8'hFF, 0, 0, 0), acc);
    step(1'b1, 16'h0080, 16'h0080, 1'b1, 1'b1, pk(0, 10'h383, 8'h80, 8'h80, 0, 0, 0), acc);
    drain();

    // stall: 3 offered with out_ready low, only 2 fit
    na = 0;
    step(1'b1, 16'h3F80, 16'h4000, 1'b0, 1'b0, '0, acc); na += int'(acc);
    step(1'b1, 16'h4000, 16'h4040, 1'b0, 1'b0, '0, acc); na += int'(acc);
    chk("stall_rdy", {31'b0, in_ready_o}, 32'd0);
    step(1'b1, 16'hBF80, 16'h4080, 1'b0, 1'b0, '0, acc); na += int'(acc);
    chk("stall_acc", na, 32'd2);
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) step(1'b1, 16'hBF80, 16'h4080, 1'b1, 1'b0, '0, acc);
    chk("third_acc", {31'b0, acc}, 32'd1);
    drain();

    // random traffic with random backpressure
    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 3) != 0, pick(), pick(), $urandom_range(0, 3) != 0, 1'b0, '0, acc);
    drain();

    // reset with 2 pairs in flight
    step(1'b1, 16'h3F80, 16'h3F80, 1'b0, 1'b0, '0, acc);
    step(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, '0, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld",  {31'b0, out_valid_o}, 32'd0);
    chk("arst_rdy",  {31'b0, in_ready_o},  32'd1);
    chk("arst_data", {2'b0, outvec()},     32'd0);
    sb.delete();
    stall_prev = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, '0, acc);
      chk("post_rst_vld", {31'b0, out_valid_o}, 32'd0);
    end
    step(1'b1, 16'hC000, 16'h4040, 1'b1, 1'b0, '0, acc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
